cache_nc_dram_adapter: RTL and testbench
========================================

# cache_nc_dram_adapter

Non-cacheable request adapter sitting directly downstream of the cache bypass stage. It accepts the per-lane word requests the bypass forwards, grants one lane at a time round-robin, and converts each into a single line-wide DRAM request. For reads it extracts the addressed word from the DRAM response and returns it on the originating lane. One transaction is outstanding at a time.

## Interface
Parameters:
- NUM_REQS, 4, number of core request lanes
- CACHE_LINE_SIZE, 64, DRAM line size in bytes (power of 2)
- WORD_SIZE, 4, word size in bytes (power of 2)
- CORE_TAG_WIDTH, 3, core tag width
- DRAM_TAG_WIDTH, 26, DRAM tag width (≥ clog2(NUM_REQS))
- Derived: WORD_ADDR_W = 32−log2(WORD_SIZE); LINE_ADDR_W = 32−log2(CACHE_LINE_SIZE); WOFF_W = log2(CACHE_LINE_SIZE/WORD_SIZE)

Ports:
- Clocking and reset (already decided): reset reset, synchronous, active-high; clock clk.
- core_req_valid in NUM_REQS: per-lane request valid
- core_req_rw in NUM_REQS: 1 = write
- core_req_addr in NUM_REQS×WORD_ADDR_W: word address
- core_req_byteen in NUM_REQS×WORD_SIZE: byte enables
- core_req_data in NUM_REQS×8·WORD_SIZE: write data
- core_req_tag in NUM_REQS×CORE_TAG_WIDTH: request tag
- core_req_ready out NUM_REQS: one-hot accept strobe
- core_rsp_valid out NUM_REQS: per-lane read response valid
- core_rsp_data out NUM_REQS×8·WORD_SIZE: response word
- core_rsp_tag out NUM_REQS×CORE_TAG_WIDTH: echoed tag
- core_rsp_ready in NUM_REQS: per-lane response ready
- dram_req_valid, dram_req_rw out 1
- dram_req_byteen out CACHE_LINE_SIZE
- dram_req_addr out LINE_ADDR_W
- dram_req_data out 8·CACHE_LINE_SIZE
- dram_req_tag out DRAM_TAG_WIDTH
- dram_req_ready in 1
- dram_rsp_valid in 1
- dram_rsp_data in 8·CACHE_LINE_SIZE
- dram_rsp_tag in DRAM_TAG_WIDTH
- dram_rsp_ready out 1

## Operation
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE: if any core_req_valid, grant the first valid lane at or after rr_ptr (cyclic). Assert core_req_ready[grant] combinationally in that cycle only. Latch rw, addr, byteen, data, tag and lane. Set rr_ptr = grant+1 mod NUM_REQS. Go to REQ.
- REQ: dram_req_valid=1. Address = latched addr[WORD_ADDR_W−1:WOFF_W]; word offset = addr[WOFF_W−1:0]. byteen = word byteen shifted left by offset·WORD_SIZE, other bits 0. Data = word replicated across all line slots. Tag = lane index zero-extended. On dram_req_ready: write → IDLE; read → WAIT.
- WAIT: dram_rsp_ready=1. On dram_rsp_valid, latch the word slice at the offset and go to RSP. dram_rsp_tag is ignored because only one transaction is outstanding.
- RSP: core_rsp_valid[lane]=1, with data and tag on that lane. On core_rsp_ready[lane] → IDLE.
- Writes produce no core response.
- DRAM request and core response outputs are held stable until the handshake completes.

## Timing
- Reset: state=IDLE, rr_ptr=0, all valid/ready outputs 0, data/addr/tag registers 0.
- Accept to dram_req_valid: 1 cycle.
- Read round trip: core accept to core_rsp_valid = 1 + DRAM request wait + DRAM latency + 1 cycle.
- Peak write throughput: one every 2 cycles.
- A DRAM response arriving in any state other than WAIT is not consumed (dram_rsp_ready=0).
- Reset mid-transaction abandons it immediately. No response is generated afterwards.
- Simultaneous valids on all lanes are granted in rr_ptr order. No lane waits more than NUM_REQS grants.
- Offset at the top slot (all ones) maps to the top bytes of the line.

## Structure
- Shared cache config package holds the WORD_ADDR_W, LINE_ADDR_W and WOFF_W derivations and the FSM state enum.
- One sub-module: cache_rr_arbiter (NUM_REQS-wide round-robin, one-hot grant plus index, advance input).

## Test plan
- Single read, lane 2, addr 0x0000_0013, tag 5; DRAM replies after 3 cycles with slot 3 = 0xDEADBEEF → dram_req_addr=0x1, byteen=0x0000_F000; core_rsp_valid=0b0100 with 0xDEADBEEF and tag 5.
- Write, lane 0, addr 0xF, byteen 0b0011, data 0x1234_5678 → dram_req_byteen bits[61:60]=1 and all other bits 0; dram_req_rw=1; no core_rsp_valid.
- All four lanes valid continuously → grants in order 0,1,2,3,0. core_req_ready is one-hot each IDLE cycle.
- dram_req_ready held low for 5 cycles → dram_req_* stable; no further core_req_ready.
- core_rsp_ready low for 4 cycles → response held; next grant only after the response handshake.
- Reset asserted in WAIT → next cycle all outputs 0, state IDLE; a subsequent DRAM response is not accepted.

Source files
------------

// File: rtl/cache_nc_dram_adapter_pkg.sv
// Shared cache configuration: address-width derivations and the non-cacheable adapter FSM states.
package cache_nc_dram_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } nc_state_e;

  function automatic int word_addr_w(input int word_size);
    return 32 - $clog2(word_size);
  endfunction

  function automatic int line_addr_w(input int line_size);
    return 32 - $clog2(line_size);
  endfunction

  function automatic int woff_w(input int line_size, input int word_size);
    return $clog2(line_size / word_size);
  endfunction

  function automatic int lane_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant + index, starting the search at rr_ptr.
// The pointer moves to the lane after the grant only when advance_i is asserted.
module cache_rr_arbiter
  import cache_nc_dram_adapter_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = lane_w(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_i,
  input  logic                advance_i,
  output logic [NUM_REQS-1:0] grant_onehot_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                grant_vld_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest lane back to rr_ptr so the nearest requester wins.
  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    grant_vld_o    = 1'b0;
    cand           = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQS);
      if (req_i[cand]) begin
        grant_onehot_o       = '0;
        grant_onehot_o[cand] = 1'b1;
        grant_idx_o          = cand;
        grant_vld_o          = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i && grant_vld_o) begin
      rr_ptr_d = (grant_idx_o == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/cache_nc_dram_adapter.sv
// Non-cacheable adapter: one granted core word request becomes one line-wide DRAM request.
// Accept to DRAM request is 1 cycle; DRAM request and core response hold until their handshakes.
module cache_nc_dram_adapter
  import cache_nc_dram_adapter_pkg::*;
#(
  parameter  int NUM_REQS        = 4,
  parameter  int CACHE_LINE_SIZE = 64,
  parameter  int WORD_SIZE       = 4,
  parameter  int CORE_TAG_WIDTH  = 3,
  parameter  int DRAM_TAG_WIDTH  = 26,
  localparam int WORD_ADDR_W     = word_addr_w(WORD_SIZE),
  localparam int LINE_ADDR_W     = line_addr_w(CACHE_LINE_SIZE),
  localparam int WOFF_W          = woff_w(CACHE_LINE_SIZE, WORD_SIZE)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_REQS-1:0]                       core_req_valid_i,
  input  logic [NUM_REQS-1:0]                       core_req_rw_i,
  input  logic [NUM_REQS-1:0][WORD_ADDR_W-1:0]      core_req_addr_i,
  input  logic [NUM_REQS-1:0][WORD_SIZE-1:0]        core_req_byteen_i,
  input  logic [NUM_REQS-1:0][8*WORD_SIZE-1:0]      core_req_data_i,
  input  logic [NUM_REQS-1:0][CORE_TAG_WIDTH-1:0]   core_req_tag_i,
  output logic [NUM_REQS-1:0]                       core_req_ready_o,
  output logic [NUM_REQS-1:0]                       core_rsp_valid_o,
  output logic [NUM_REQS-1:0][8*WORD_SIZE-1:0]      core_rsp_data_o,
  output logic [NUM_REQS-1:0][CORE_TAG_WIDTH-1:0]   core_rsp_tag_o,
  input  logic [NUM_REQS-1:0]                       core_rsp_ready_i,
  output logic                                      dram_req_valid_o,
  output logic                                      dram_req_rw_o,
  output logic [CACHE_LINE_SIZE-1:0]                dram_req_byteen_o,
  output logic [LINE_ADDR_W-1:0]                    dram_req_addr_o,
  output logic [8*CACHE_LINE_SIZE-1:0]              dram_req_data_o,
  output logic [DRAM_TAG_WIDTH-1:0]                 dram_req_tag_o,
  input  logic                                      dram_req_ready_i,
  input  logic                                      dram_rsp_valid_i,
  input  logic [8*CACHE_LINE_SIZE-1:0]              dram_rsp_data_i,
  input  logic [DRAM_TAG_WIDTH-1:0]                 dram_rsp_tag_i,
  output logic                                      dram_rsp_ready_o
);

  localparam int WORD_W = 8 * WORD_SIZE;
  localparam int SLOTS  = CACHE_LINE_SIZE / WORD_SIZE;
  localparam int LANE_W = lane_w(NUM_REQS);

  nc_state_e                 state_q, state_d;
  logic                      rw_q, rw_d;
  logic [WORD_ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0]      byteen_q, byteen_d;
  logic [WORD_W-1:0]         data_q, data_d;
  logic [CORE_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [WORD_W-1:0]         rsp_data_q, rsp_data_d;

  logic [NUM_REQS-1:0] grant_oh;
  logic [LANE_W-1:0]   grant_idx;
  logic                grant_vld;
  logic                arb_advance;
  logic [WOFF_W-1:0]   woff;

  // Only one transaction is ever in flight, so the DRAM tag carries no information back.
  logic unused_rsp_tag;
  assign unused_rsp_tag = ^dram_rsp_tag_i;

  assign woff = addr_q[WOFF_W-1:0];

  cache_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk            (clk),
    .reset          (reset),
    .req_i          (core_req_valid_i),
    .advance_i      (arb_advance),
    .grant_onehot_o (grant_oh),
    .grant_idx_o    (grant_idx),
    .grant_vld_o    (grant_vld)
  );

  always_comb begin
    state_d          = state_q;
    rw_d             = rw_q;
    addr_d           = addr_q;
    byteen_d         = byteen_q;
    data_d           = data_q;
    tag_d            = tag_q;
    lane_d           = lane_q;
    rsp_data_d       = rsp_data_q;
    arb_advance      = 1'b0;
    core_req_ready_o = '0;
    core_rsp_valid_o = '0;
    dram_req_valid_o = 1'b0;
    dram_rsp_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Gate on reset so no request is acknowledged during the cycle it is being abandoned.
        if (grant_vld && !reset) begin
          core_req_ready_o = grant_oh;
          arb_advance      = 1'b1;
          rw_d             = core_req_rw_i[grant_idx];
          addr_d           = core_req_addr_i[grant_idx];
          byteen_d         = core_req_byteen_i[grant_idx];
          data_d           = core_req_data_i[grant_idx];
          tag_d            = core_req_tag_i[grant_idx];
          lane_d           = grant_idx;
          state_d          = REQ;
        end
      end
      REQ: begin
        dram_req_valid_o = 1'b1;
        if (dram_req_ready_i) state_d = rw_q ? IDLE : WAIT;
      end
      WAIT: begin
        dram_rsp_ready_o = 1'b1;
        if (dram_rsp_valid_i) begin
          rsp_data_d = dram_rsp_data_i[int'(woff) * WORD_W +: WORD_W];
          state_d    = RSP;
        end
      end
      RSP: begin
        core_rsp_valid_o[lane_q] = 1'b1;
        if (core_rsp_ready_i[lane_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dram_req_rw_o     = rw_q;
  assign dram_req_addr_o   = addr_q[WORD_ADDR_W-1:WOFF_W];
  assign dram_req_byteen_o = CACHE_LINE_SIZE'(byteen_q) << (int'(woff) * WORD_SIZE);
  assign dram_req_data_o   = {SLOTS{data_q}};
  assign dram_req_tag_o    = DRAM_TAG_WIDTH'(lane_q);

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      core_rsp_data_o[i] = '0;
      core_rsp_tag_o[i]  = '0;
      if (state_q == RSP && lane_q == LANE_W'(i)) begin
        core_rsp_data_o[i] = rsp_data_q;
        core_rsp_tag_o[i]  = tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      byteen_q   <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      lane_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      byteen_q   <= byteen_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      lane_q     <= lane_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cache_nc_dram_adapter.sv
// Bench for cache_nc_dram_adapter: directed scenarios plus randomized transactions vs a behavioural model.
module tb_cache_nc_dram_adapter;

  localparam int N = 4, LS = 64, WS = 4, CTW = 3, DTW = 26;
  localparam int WAW = 30, LAW = 26, WW = 32, LW = 512, SLOTS = 16;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]          core_req_valid, core_req_rw, core_req_ready;
  logic [N-1:0][WAW-1:0] core_req_addr;
  logic [N-1:0][WS-1:0]  core_req_byteen;
  logic [N-1:0][WW-1:0]  core_req_data;
  logic [N-1:0][CTW-1:0] core_req_tag;
  logic [N-1:0]          core_rsp_valid, core_rsp_ready;
  logic [N-1:0][WW-1:0]  core_rsp_data;
  logic [N-1:0][CTW-1:0] core_rsp_tag;
  logic                  dram_req_valid, dram_req_rw, dram_req_ready;
  logic [LS-1:0]         dram_req_byteen;
  logic [LAW-1:0]        dram_req_addr;
  logic [LW-1:0]         dram_req_data, dram_rsp_data;
  logic [DTW-1:0]        dram_req_tag, dram_rsp_tag;
  logic                  dram_rsp_valid, dram_rsp_ready;

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  cache_nc_dram_adapter dut (
    .clk               (clk),
    .reset             (reset),
    .core_req_valid_i  (core_req_valid),
    .core_req_rw_i     (core_req_rw),
    .core_req_addr_i   (core_req_addr),
    .core_req_byteen_i (core_req_byteen),
    .core_req_data_i   (core_req_data),
    .core_req_tag_i    (core_req_tag),
    .core_req_ready_o  (core_req_ready),
    .core_rsp_valid_o  (core_rsp_valid),
    .core_rsp_data_o   (core_rsp_data),
    .core_rsp_tag_o    (core_rsp_tag),
    .core_rsp_ready_i  (core_rsp_ready),
    .dram_req_valid_o  (dram_req_valid),
    .dram_req_rw_o     (dram_req_rw),
    .dram_req_byteen_o (dram_req_byteen),
    .dram_req_addr_o   (dram_req_addr),
    .dram_req_data_o   (dram_req_data),
    .dram_req_tag_o    (dram_req_tag),
    .dram_req_ready_i  (dram_req_ready),
    .dram_rsp_valid_i  (dram_rsp_valid),
    .dram_rsp_data_i   (dram_rsp_data),
    .dram_rsp_tag_i    (dram_rsp_tag),
    .dram_rsp_ready_o  (dram_rsp_ready)
  );

  // ---------------- behavioural model ----------------
  function automatic int exp_grant(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [LS-1:0] exp_byteen(input logic [WAW-1:0] a, input logic [WS-1:0] be);
    logic [LS-1:0] r;
    int off;
    r = '0;
    off = int'(a % 16);
    for (int b = 0; b < WS; b++) r[off * WS + b] = be[b];
    return r;
  endfunction

  function automatic logic [LW-1:0] exp_line_data(input logic [WW-1:0] d);
    logic [LW-1:0] r;
    for (int s = 0; s < SLOTS; s++) r[s * WW +: WW] = d;
    return r;
  endfunction

  function automatic logic [WW-1:0] exp_word(input logic [LW-1:0] line, input int off);
    logic [LW-1:0] s;
    s = line >> (off * WW);
    return s[WW-1:0];
  endfunction

  function automatic logic [LW-1:0] random_line();
    logic [LW-1:0] r;
    for (int s = 0; s < SLOTS; s++) r[s * WW +: WW] = $urandom;
    return r;
  endfunction

  task automatic scramble_lanes();
    for (int i = 0; i < N; i++) begin
      core_req_rw[i]     = 1'($urandom_range(0, 1));
      core_req_addr[i]   = WAW'($urandom);
      core_req_byteen[i] = WS'($urandom);
      core_req_data[i]   = $urandom;
      core_req_tag[i]    = CTW'($urandom);
    end
  endtask

  task automatic idle_inputs();
    core_req_valid = '0;
    core_rsp_ready = '0;
    dram_req_ready = 1'b0;
    dram_rsp_valid = 1'b0;
    dram_rsp_data  = '0;
    dram_rsp_tag   = '0;
    scramble_lanes();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    core_req_valid = 4'hF;
    dram_rsp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({core_req_ready, core_rsp_valid, dram_req_valid, dram_rsp_ready} !== 10'b0) begin
      failures++;
      $display("FAIL reset_handshakes got req_rdy=%b rsp_vld=%b dreq_vld=%b drsp_rdy=%b want all 0",
               core_req_ready, core_rsp_valid, dram_req_valid, dram_rsp_ready);
    end
    checks++;
    if ({dram_req_rw, dram_req_addr, dram_req_byteen, dram_req_tag} !== '0) begin
      failures++;
      $display("FAIL reset_dram_fields got rw=%b addr=%0h be=%0h tag=%0h want 0",
               dram_req_rw, dram_req_addr, dram_req_byteen, dram_req_tag);
    end
    checks++;
    if ({dram_req_data, core_rsp_data, core_rsp_tag} !== '0) begin
      failures++;
      $display("FAIL reset_data got dram_data=%0h rsp_data=%0h rsp_tag=%0h want 0",
               dram_req_data, core_rsp_data, core_rsp_tag);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    exp_ptr = 0;
  endtask

  task automatic test_single_read();
    logic [LW-1:0] line;
    @(negedge clk);
    core_req_valid = 4'b0100;
    core_req_rw[2] = 1'b0;
    core_req_addr[2] = 30'h13;
    core_req_byteen[2] = 4'hF;
    core_req_tag[2] = 3'd5;
    #1;
    checks++;
    if (core_req_ready !== 4'b0100) begin
      failures++; $display("FAIL rd_accept got=%b want=0100", core_req_ready);
    end
    @(negedge clk);
    core_req_valid = '0;
    dram_req_ready = 1'b1;
    #1;
    checks++;
    if ({dram_req_valid, dram_req_rw, dram_req_addr, dram_req_byteen, dram_req_tag} !==
        {1'b1, 1'b0, 26'h1, 64'h0000_0000_0000_F000, 26'd2}) begin
      failures++;
      $display("FAIL rd_dram_req got vld=%b rw=%b addr=%0h be=%0h tag=%0h want 1 0 1 f000 2",
               dram_req_valid, dram_req_rw, dram_req_addr, dram_req_byteen, dram_req_tag);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dram_req_ready = 1'b0;
      line = random_line();
      line[3 * WW +: WW] = 32'hDEAD_BEEF;
      dram_rsp_valid = (c == 2);
      dram_rsp_data = line;
      dram_rsp_tag = DTW'($urandom);
      #1;
      checks++;
      if ({dram_rsp_ready, dram_req_valid, core_rsp_valid} !== {1'b1, 1'b0, 4'b0}) begin
        failures++;
        $display("FAIL rd_wait c=%0d got drsp_rdy=%b dreq_vld=%b rsp_vld=%b want 1 0 0000",
                 c, dram_rsp_ready, dram_req_valid, core_rsp_valid);
      end
    end
    @(negedge clk);
    dram_rsp_valid = 1'b0;
    core_rsp_ready = 4'b0100;
    #1;
    checks++;
    if ({core_rsp_valid, core_rsp_data[2], core_rsp_tag[2]} !== {4'b0100, 32'hDEAD_BEEF, 3'd5}) begin
      failures++;
      $display("FAIL rd_rsp got vld=%b data=%0h tag=%0d want 0100 deadbeef 5",
               core_rsp_valid, core_rsp_data[2], core_rsp_tag[2]);
    end
    @(negedge clk);
    core_rsp_ready = '0;
    #1;
    checks++;
    if (core_rsp_valid !== 4'b0) begin
      failures++; $display("FAIL rd_rsp_done got=%b want=0000", core_rsp_valid);
    end
    exp_ptr = 3;
  endtask

  task automatic test_write();
    @(negedge clk);
    core_req_valid = 4'b0001;
    core_req_rw[0] = 1'b1;
    core_req_addr[0] = 30'hF;
    core_req_byteen[0] = 4'b0011;
    core_req_data[0] = 32'h1234_5678;
    #1;
    checks++;
    if (core_req_ready !== 4'b0001) begin
      failures++; $display("FAIL wr_accept got=%b want=0001", core_req_ready);
    end
    @(negedge clk);
    core_req_valid = '0;
    dram_req_ready = 1'b1;
    #1;
    checks++;
    if ({dram_req_valid, dram_req_rw, dram_req_addr, dram_req_byteen, dram_req_tag} !==
        {1'b1, 1'b1, 26'h0, 64'h3000_0000_0000_0000, 26'd0}) begin
      failures++;
      $display("FAIL wr_dram_req got vld=%b rw=%b addr=%0h be=%0h tag=%0h want 1 1 0 3000000000000000 0",
               dram_req_valid, dram_req_rw, dram_req_addr, dram_req_byteen, dram_req_tag);
    end
    checks++;
    if (dram_req_data !== {SLOTS{32'h1234_5678}}) begin
      failures++; $display("FAIL wr_dram_data got=%0h want 16x12345678", dram_req_data);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dram_req_ready = 1'b0;
      #1;
      checks++;
      if ({core_rsp_valid, dram_req_valid, dram_rsp_ready} !== 6'b0) begin
        failures++;
        $display("FAIL wr_no_rsp c=%0d got rsp_vld=%b dreq_vld=%b drsp_rdy=%b want 0",
                 c, core_rsp_valid, dram_req_valid, dram_rsp_ready);
      end
    end
    exp_ptr = 1;
  endtask

  task automatic test_back_to_back();
    int g;
    logic [WAW-1:0] a;
    logic [WS-1:0] be;
    logic [WW-1:0] d;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      scramble_lanes();
      core_req_rw = '1;
      core_req_valid = 4'hF;
      dram_req_ready = 1'b1;
      #1;
      g = exp_grant(4'hF, exp_ptr);
      a = core_req_addr[g];
      be = core_req_byteen[g];
      d = core_req_data[g];
      checks++;
      if (core_req_ready !== 4'(1 << g)) begin
        failures++; $display("FAIL b2b_grant k=%0d got=%b want lane %0d", k, core_req_ready, g);
      end
      @(negedge clk);
      scramble_lanes();
      #1;
      checks++;
      if ({dram_req_valid, dram_req_rw, core_req_ready, dram_req_tag, dram_req_addr, dram_req_byteen} !==
          {1'b1, 1'b1, 4'b0, DTW'(g), LAW'(a >> 4), exp_byteen(a, be)}) begin
        failures++;
        $display("FAIL b2b_req k=%0d got vld=%b rw=%b rdy=%b tag=%0h addr=%0h be=%0h want tag=%0d addr=%0h be=%0h",
                 k, dram_req_valid, dram_req_rw, core_req_ready, dram_req_tag, dram_req_addr,
                 dram_req_byteen, g, a >> 4, exp_byteen(a, be));
      end
      checks++;
      if (dram_req_data !== exp_line_data(d)) begin
        failures++; $display("FAIL b2b_data k=%0d got=%0h want word %0h", k, dram_req_data, d);
      end
      exp_ptr = (g + 1) % N;
    end
    @(negedge clk);
    core_req_valid = '0;
    dram_req_ready = 1'b0;
  endtask

  task automatic test_req_backpressure();
    int g;
    logic [WAW-1:0] a;
    logic [WS-1:0] be;
    logic [WW-1:0] d;
    logic [LW-1:0] line;
    @(negedge clk);
    scramble_lanes();
    core_req_rw = '0;
    core_req_valid = 4'hF;
    #1;
    g = exp_grant(4'hF, exp_ptr);
    a = core_req_addr[g]; be = core_req_byteen[g]; d = core_req_data[g];
    checks++;
    if (core_req_ready !== 4'(1 << g)) begin
      failures++; $display("FAIL bp_grant got=%b want lane %0d", core_req_ready, g);
    end
    exp_ptr = (g + 1) % N;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      scramble_lanes();
      dram_req_ready = (c == 5);
      dram_rsp_valid = 1'b1;
      #1;
      checks++;
      if ({dram_req_valid, dram_req_rw, core_req_ready, dram_rsp_ready, dram_req_tag, dram_req_addr,
           dram_req_byteen} !== {1'b1, 1'b0, 4'b0, 1'b0, DTW'(g), LAW'(a >> 4), exp_byteen(a, be)}) begin
        failures++;
        $display("FAIL bp_stall c=%0d got vld=%b rw=%b rdy=%b drsp_rdy=%b tag=%0h addr=%0h be=%0h",
                 c, dram_req_valid, dram_req_rw, core_req_ready, dram_rsp_ready, dram_req_tag,
                 dram_req_addr, dram_req_byteen);
      end
      checks++;
      if (dram_req_data !== exp_line_data(d)) begin
        failures++; $display("FAIL bp_stall_data c=%0d got=%0h want word %0h", c, dram_req_data, d);
      end
    end
    @(negedge clk);
    dram_req_ready = 1'b0;
    core_req_valid = '0;
    line = random_line();
    dram_rsp_data = line;
    @(negedge clk);
    dram_rsp_valid = 1'b0;
    core_rsp_ready = 4'(1 << g);
    #1;
    checks++;
    if ({core_rsp_valid, core_rsp_data[g]} !== {4'(1 << g), exp_word(line, int'(a % 16))}) begin
      failures++;
      $display("FAIL bp_rsp got vld=%b data=%0h want lane %0d data %0h",
               core_rsp_valid, core_rsp_data[g], g, exp_word(line, int'(a % 16)));
    end
    @(negedge clk);
    core_rsp_ready = '0;
  endtask

  task automatic test_rsp_hold();
    int g, g2;
    logic [WAW-1:0] a;
    logic [CTW-1:0] t;
    logic [LW-1:0] line;
    @(negedge clk);
    scramble_lanes();
    core_req_rw = '0;
    core_req_valid = 4'hF;
    #1;
    g = exp_grant(4'hF, exp_ptr);
    a = core_req_addr[g]; t = core_req_tag[g];
    exp_ptr = (g + 1) % N;
    @(negedge clk);
    dram_req_ready = 1'b1;
    @(negedge clk);
    dram_req_ready = 1'b0;
    line = random_line();
    dram_rsp_data = line;
    dram_rsp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dram_rsp_valid = 1'b0;
      dram_rsp_data = random_line();
      core_rsp_ready = (c == 4) ? 4'(1 << g) : ~4'(1 << g);
      #1;
      checks++;
      if ({core_rsp_valid, core_req_ready, core_rsp_data[g], core_rsp_tag[g]} !==
          {4'(1 << g), 4'b0, exp_word(line, int'(a % 16)), t}) begin
        failures++;
        $display("FAIL hold_rsp c=%0d got vld=%b req_rdy=%b data=%0h tag=%0d want lane %0d data %0h tag %0d",
                 c, core_rsp_valid, core_req_ready, core_rsp_data[g], core_rsp_tag[g], g,
                 exp_word(line, int'(a % 16)), t);
      end
    end
    @(negedge clk);
    core_rsp_ready = '0;
    #1;
    g2 = exp_grant(4'hF, exp_ptr);
    checks++;
    if ({core_rsp_valid, core_req_ready} !== {4'b0, 4'(1 << g2)}) begin
      failures++;
      $display("FAIL hold_next_grant got rsp_vld=%b req_rdy=%b want 0000 lane %0d",
               core_rsp_valid, core_req_ready, g2);
    end
    core_req_valid = '0;
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    core_req_valid = 4'b0010;
    core_req_rw[1] = 1'b0;
    @(negedge clk);
    core_req_valid = '0;
    dram_req_ready = 1'b1;
    @(negedge clk);
    dram_req_ready = 1'b0;
    #1;
    checks++;
    if (dram_rsp_ready !== 1'b1) begin
      failures++; $display("FAIL rst_wait_entry got drsp_rdy=%b want 1", dram_rsp_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({core_req_ready, core_rsp_valid, dram_req_valid, dram_rsp_ready, dram_req_addr, dram_req_tag,
         dram_req_byteen} !== '0) begin
      failures++;
      $display("FAIL rst_wait_outputs got req_rdy=%b rsp_vld=%b dreq_vld=%b drsp_rdy=%b addr=%0h tag=%0h be=%0h",
               core_req_ready, core_rsp_valid, dram_req_valid, dram_rsp_ready, dram_req_addr,
               dram_req_tag, dram_req_byteen);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dram_rsp_valid = 1'b1;
      dram_rsp_data = random_line();
      core_rsp_ready = 4'hF;
      #1;
      checks++;
      if ({dram_rsp_ready, core_rsp_valid} !== 5'b0) begin
        failures++;
        $display("FAIL rst_wait_stale c=%0d got drsp_rdy=%b rsp_vld=%b want 0", c, dram_rsp_ready, core_rsp_valid);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    int g, stall, lat, hold;
    logic [N-1:0] mask;
    logic rw_e;
    logic [WAW-1:0] a;
    logic [WS-1:0] be;
    logic [WW-1:0] d;
    logic [CTW-1:0] t;
    logic [LW-1:0] line;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      scramble_lanes();
      mask = 4'($urandom_range(1, 15));
      core_req_valid = mask;
      #1;
      g = exp_grant(mask, exp_ptr);
      rw_e = core_req_rw[g]; a = core_req_addr[g]; be = core_req_byteen[g];
      d = core_req_data[g]; t = core_req_tag[g];
      checks++;
      if (core_req_ready !== 4'(1 << g)) begin
        failures++; $display("FAIL rnd_grant n=%0d mask=%b got=%b want lane %0d", n, mask, core_req_ready, g);
      end
      exp_ptr = (g + 1) % N;
      stall = $urandom_range(0, 3);
      for (int c = 0; c <= stall; c++) begin
        @(negedge clk);
        core_req_valid = '0;
        scramble_lanes();
        dram_req_ready = (c == stall);
        dram_rsp_valid = 1'($urandom_range(0, 1));
        dram_rsp_data = random_line();
        #1;
        checks++;
        if ({dram_req_valid, dram_req_rw, dram_rsp_ready, core_req_ready, dram_req_tag, dram_req_addr,
             dram_req_byteen} !== {1'b1, rw_e, 1'b0, 4'b0, DTW'(g), LAW'(a >> 4), exp_byteen(a, be)}) begin
          failures++;
          $display("FAIL rnd_req n=%0d got vld=%b rw=%b drsp_rdy=%b tag=%0h addr=%0h be=%0h want rw=%b tag=%0d addr=%0h be=%0h",
                   n, dram_req_valid, dram_req_rw, dram_rsp_ready, dram_req_tag, dram_req_addr,
                   dram_req_byteen, rw_e, g, a >> 4, exp_byteen(a, be));
        end
        checks++;
        if (dram_req_data !== exp_line_data(d)) begin
          failures++; $display("FAIL rnd_req_data n=%0d got=%0h want word %0h", n, dram_req_data, d);
        end
      end
      @(negedge clk);
      dram_req_ready = 1'b0;
      dram_rsp_valid = 1'b0;
      if (rw_e) begin
        #1;
        checks++;
        if ({dram_req_valid, dram_rsp_ready, core_rsp_valid} !== 6'b0) begin
          failures++;
          $display("FAIL rnd_wr_done n=%0d got dreq_vld=%b drsp_rdy=%b rsp_vld=%b want 0",
                   n, dram_req_valid, dram_rsp_ready, core_rsp_valid);
        end
      end else begin
        lat = $urandom_range(0, 3);
        for (int c = 0; c <= lat; c++) begin
          if (c > 0) @(negedge clk);
          line = random_line();
          dram_rsp_data = line;
          dram_rsp_tag = DTW'($urandom);
          dram_rsp_valid = (c == lat);
          #1;
          checks++;
          if ({dram_rsp_ready, dram_req_valid, core_rsp_valid} !== {1'b1, 1'b0, 4'b0}) begin
            failures++;
            $display("FAIL rnd_wait n=%0d c=%0d got drsp_rdy=%b dreq_vld=%b rsp_vld=%b",
                     n, c, dram_rsp_ready, dram_req_valid, core_rsp_valid);
          end
        end
        hold = $urandom_range(0, 3);
        for (int c = 0; c <= hold; c++) begin
          @(negedge clk);
          dram_rsp_valid = 1'b0;
          dram_rsp_data = random_line();
          core_rsp_ready = (c == hold) ? 4'(1 << g) : (4'($urandom) & ~4'(1 << g));
          #1;
          checks++;
          if ({core_rsp_valid, core_req_ready, dram_rsp_ready, core_rsp_data[g], core_rsp_tag[g]} !==
              {4'(1 << g), 4'b0, 1'b0, exp_word(line, int'(a % 16)), t}) begin
            failures++;
            $display("FAIL rnd_rsp n=%0d got vld=%b data=%0h tag=%0d want lane %0d data %0h tag %0d",
                     n, core_rsp_valid, core_rsp_data[g], core_rsp_tag[g], g,
                     exp_word(line, int'(a % 16)), t);
          end
        end
        @(negedge clk);
        core_rsp_ready = '0;
        #1;
        checks++;
        if (core_rsp_valid !== 4'b0) begin
          failures++; $display("FAIL rnd_rsp_done n=%0d got=%b want 0000", n, core_rsp_valid);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_req_backpressure();
    test_rsp_hold();
    test_reset_in_wait();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
